// File: rtl/display_pkg.sv
// Shared types and defaults for the multiplexed BCD display driver.
package display_pkg;

    typedef logic [3:0] bcd_t;

    localparam bcd_t BCD_MAX      = 4'd9;
    localparam int   DIGITS_DEF   = 4;
    localparam int   PRESCALE_DEF = 1000;
    localparam int   BLANK_DEF    = 2;

endpackage

// File: rtl/scan_tick.sv
// Digit-slot prescaler: cnt runs 0..PRESCALE-1 and tick marks the last cycle of each slot.
module scan_tick
    import display_pkg::*;
#(
    parameter int PRESCALE = PRESCALE_DEF
) (
    input  logic                        clk,
    input  logic                        rst_n,
    output logic [$clog2(PRESCALE)-1:0] cnt,
    output logic                        tick
);

    localparam int            CW   = $clog2(PRESCALE);
    localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

    assign tick = (cnt == LAST);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/display_mux.sv
// Time-multiplexed BCD digit driver with per-slot anode blanking and a bad-digit flag.
// Define DISPLAY_MUX_LZB_EN to enable leading-zero blanking of the anodes.
module display_mux
    import display_pkg::*;
#(
    parameter int DIGITS   = DIGITS_DEF,
    parameter int PRESCALE = PRESCALE_DEF,
    parameter int BLANK    = BLANK_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ld,
    input  logic [4*DIGITS-1:0]   din,
    output bcd_t                  d,
    output logic [DIGITS-1:0]     an,
    output logic                  err
);

    localparam int            CW        = $clog2(PRESCALE);
    localparam int            IW        = $clog2(DIGITS);
    localparam logic [IW-1:0] IDX_LAST  = IW'(DIGITS - 1);
    localparam logic [CW-1:0] BLANK_END = CW'(BLANK);

    logic [CW-1:0]       cnt;
    logic                tick;
    logic [IW-1:0]       idx;
    bcd_t [DIGITS-1:0]   buffer;
    logic [DIGITS-1:0]   an_next;
    logic                err_next;
    logic                lz_blank;

    scan_tick #(.PRESCALE(PRESCALE)) u_scan_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .cnt   (cnt),
        .tick  (tick)
    );

    // Load and scan advance are independent, so a load on a tick lands in the new slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buffer <= '0;
            idx    <= '0;
        end else begin
            if (ld) begin
                buffer <= din;
            end
            if (tick) begin
                idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
            end
        end
    end

`ifdef DISPLAY_MUX_LZB_EN
    logic [IW-1:0] msd;

    // Highest nonzero digit; an all-zero buffer leaves digit 0 as the one shown.
    always_comb begin
        msd = '0;
        for (int i = 1; i < DIGITS; i++) begin
            if (buffer[i] != '0) begin
                msd = IW'(i);
            end
        end
    end

    assign lz_blank = (idx > msd);
`else
    assign lz_blank = 1'b0;
`endif

    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        an_next  = '1;
        err_next = 1'b0;
        if (cnt >= BLANK_END && !lz_blank) begin
            an_next[idx] = 1'b0;
        end
        for (int i = 0; i < DIGITS; i++) begin
            if (buffer[i] > BCD_MAX) begin
                err_next = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d   <= '0;
            an  <= '1;
            err <= 1'b0;
        end else begin
            d   <= buffer[idx];
            an  <= an_next;
            err <= err_next;
        end
    end

endmodule

// File: tb/tb_display_mux.sv
// Directed self-checking bench for display_mux with DIGITS=4, PRESCALE=4, BLANK=1.
module tb_display_mux;

    logic        clk;
    logic        rst_n;
    logic        ld;
    logic [15:0] din;
    logic [3:0]  d;
    logic [3:0]  an;
    logic        err;

    int checks = 0;
    int errors = 0;

    // Outputs after scan edges 2..20 following the 16'h1234 load.
    logic [3:0] scan_an [19] = '{
        4'b1110, 4'b1110, 4'b1110,
        4'b1111, 4'b1101, 4'b1101, 4'b1101,
        4'b1111, 4'b1011, 4'b1011, 4'b1011,
        4'b1111, 4'b0111, 4'b0111, 4'b0111,
        4'b1111, 4'b1110, 4'b1110, 4'b1110
    };
    logic [3:0] scan_d [19] = '{
        4'h4, 4'h4, 4'h4,
        4'h3, 4'h3, 4'h3, 4'h3,
        4'h2, 4'h2, 4'h2, 4'h2,
        4'h1, 4'h1, 4'h1, 4'h1,
        4'h4, 4'h4, 4'h4, 4'h4
    };

`ifdef DISPLAY_MUX_LZB_EN
    localparam logic [3:0] AN_SLOT2_0042 = 4'b1111;
    localparam logic [3:0] AN_SLOT3_0042 = 4'b1111;
    localparam logic [3:0] AN_SLOT3_0000 = 4'b1111;
`else
    localparam logic [3:0] AN_SLOT2_0042 = 4'b1011;
    localparam logic [3:0] AN_SLOT3_0042 = 4'b0111;
    localparam logic [3:0] AN_SLOT3_0000 = 4'b0111;
`endif

    display_mux #(
        .DIGITS   (4),
        .PRESCALE (4),
        .BLANK    (1)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .ld    (ld),
        .din   (din),
        .d     (d),
        .an    (an),
        .err   (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        ld    = 1'b0;
        din   = '0;

        // Reset held for three cycles
        for (int i = 0; i < 3; i++) begin
            step();
            check("rst_an", 16'(an), 16'h000f);
            check("rst_d", 16'(d), 16'h0000);
        end
        check("rst_err", 16'(err), 16'h0000);

        // Release and load 1234 straight away; first slot blanks for one cycle
        rst_n = 1'b1;
        ld    = 1'b1;
        din   = 16'h1234;
        step();
        ld    = 1'b0;
        check("first_blank_an", 16'(an), 16'h000f);
        check("first_blank_d", 16'(d), 16'h0000);
        for (int i = 0; i < 19; i++) begin
            step();
            check("scan_an", 16'(an), 16'(scan_an[i]));
            check("scan_d", 16'(d), 16'(scan_d[i]));
        end
        check("scan_err", 16'(err), 16'h0000);

        // Non-BCD nibble in digit 1, then clear
        ld  = 1'b1;
        din = 16'h12a4;
        step();
        ld  = 1'b0;
        step();
        check("bad_err", 16'(err), 16'h0001);
        check("bad_d", 16'(d), 16'h000a);
        check("bad_an", 16'(an), 16'h000d);
        step();
        check("bad_d_hold", 16'(d), 16'h000a);
        step();
        check("bad_d_end", 16'(d), 16'h000a);
        step();
        check("slot2_d", 16'(d), 16'h0002);
        check("slot2_blank", 16'(an), 16'h000f);
        ld  = 1'b1;
        din = 16'h0000;
        step();
        ld  = 1'b0;
        check("err_hold", 16'(err), 16'h0001);
        step();
        check("err_clear", 16'(err), 16'h0000);
        check("clear_d", 16'(d), 16'h0000);
        check("clear_an", 16'(an), 16'h000b);

        // Load on the tick from slot 0 to slot 1, ld held for five cycles
        repeat (8) step();
        ld  = 1'b1;
        din = 16'h5678;
        step();
        check("tick_ld_old_d", 16'(d), 16'h0000);
        check("tick_ld_old_an", 16'(an), 16'h000e);
        step();
        check("tick_ld_d", 16'(d), 16'h0007);
        check("tick_ld_an", 16'(an), 16'h000f);
        for (int i = 0; i < 3; i++) begin
            step();
            check("ld_held_d", 16'(d), 16'h0007);
            check("ld_held_an", 16'(an), 16'h000d);
        end
        ld = 1'b0;
        step();
        check("slot2_5678_d", 16'(d), 16'h0006);
        check("slot2_5678_an", 16'(an), 16'h000f);
        step();
        check("slot2_5678_on", 16'(an), 16'h000b);
        check("ld_err", 16'(err), 16'h0000);
        step();
        check("pre_rst_an", 16'(an), 16'h000b);

        // Asynchronous reset in the middle of digit 2
        rst_n = 1'b0;
        #1;
        check("async_rst_an", 16'(an), 16'h000f);
        check("async_rst_d", 16'(d), 16'h0000);
        check("async_rst_err", 16'(err), 16'h0000);
        step();
        step();
        check("rst_hold_an", 16'(an), 16'h000f);
        rst_n = 1'b1;
        step();
        check("restart_blank", 16'(an), 16'h000f);
        check("restart_d", 16'(d), 16'h0000);
        step();
        check("restart_dig0", 16'(an), 16'h000e);
        step();
        step();
        check("restart_dig0_end", 16'(an), 16'h000e);
        step();
        check("restart_slot1_blank", 16'(an), 16'h000f);
        step();
        check("restart_dig1", 16'(an), 16'h000d);

        // Leading zeros: 0042 then 0000
        step();
        ld  = 1'b1;
        din = 16'h0042;
        step();
        ld  = 1'b0;
        step();
        check("lz_slot2_blank", 16'(an), 16'h000f);
        check("lz_err", 16'(err), 16'h0000);
        step();
        check("lz_slot2_an", 16'(an), 16'(AN_SLOT2_0042));
        check("lz_slot2_d", 16'(d), 16'h0000);
        repeat (3) step();
        step();
        check("lz_slot3_an", 16'(an), 16'(AN_SLOT3_0042));
        repeat (2) step();
        step();
        check("lz_slot0_d", 16'(d), 16'h0002);
        check("lz_slot0_blank", 16'(an), 16'h000f);
        step();
        check("lz_slot0_an", 16'(an), 16'h000e);
        repeat (2) step();
        step();
        check("lz_slot1_d", 16'(d), 16'h0004);
        step();
        check("lz_slot1_an", 16'(an), 16'h000d);
        repeat (2) step();
        ld  = 1'b1;
        din = 16'h0000;
        step();
        ld  = 1'b0;
        repeat (5) step();
        check("zero_slot3_an", 16'(an), 16'(AN_SLOT3_0000));
        repeat (3) step();
        check("zero_slot0_blank", 16'(an), 16'h000f);
        step();
        check("zero_slot0_an", 16'(an), 16'h000e);
        check("zero_slot0_d", 16'(d), 16'h0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
